block_mem_backend: RTL
======================

// Module: block_mem_backend
// PURPOSE
//  Block-granular main-memory model directly downstream of the data cache.
//  - Serves one cache request at a time: block refill (read) or dirty-block writeback (write).
//  - Models DRAM access time with a programmable fixed latency.
//  - Presents a one-cycle ready pulse back to the cache controller.
// PARAMETERS
//  BLOCK_BITS   128  width of one cache block (data path width)
//  OFFSET_BITS  4    byte-offset bits inside a block; log2(BLOCK_BITS/8)
//  DEPTH_LOG2   10   log2 of number of blocks stored (1024 blocks)
//  LATENCY      4    cycles from request acceptance to resp_ready; legal range 1..255
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous, active-low reset
//  req_valid   in   1           request present
//  req_write   in   1           1 = writeback block, 0 = refill read
//  req_addr    in   32          byte address; bits [OFFSET_BITS-1:0] ignored
//  req_wdata   in   BLOCK_BITS  block to write
//  req_wmask   in   BLOCK_BITS/8  byte enables; only present with BLOCK_MEM_WMASK_EN
//  req_ready   out  1           high while idle: request accepted this edge if req_valid
//  resp_ready  out  1           one-cycle completion pulse
//  resp_rdata  out  BLOCK_BITS  read block; valid in the resp_ready cycle, held until next read completes
// BEHAVIOUR
//  - Storage: reg array mem[0:2**DEPTH_LOG2-1]; index = req_addr[OFFSET_BITS+DEPTH_LOG2-1:OFFSET_BITS].
//    Upper address bits ignored: addresses alias modulo the memory size.
//  - Reset: mem contents untouched; bench preloads it hierarchically.
//  - Reset values: req_ready=1, resp_ready=0, resp_rdata=0, state=IDLE, counter=0.
//  - FSM:
//    IDLE: req_ready=1. On req_valid, capture write, index, wdata (and mask) into registers;
//          counter<=LATENCY-1; go to BUSY.
//    BUSY: req_ready=0; inputs ignored. Counter decrements each cycle; at 0 go to RESP.
//    RESP: one cycle, resp_ready=1.
//          Read: resp_rdata<=mem[idx], registered so it is valid in this cycle.
//          Write: mem[idx] commits at the end of this cycle.
//          Next state is IDLE.
//  - Latency: acceptance at edge E0 -> resp_ready high during cycle E0+LATENCY. LATENCY=1 skips BUSY.
//  - Upstream may drop req_valid or change inputs after acceptance; captured values are used.
//  - Back-to-back requests: a request held through RESP is accepted in the following IDLE cycle.
//    Minimum spacing between acceptances is therefore LATENCY+1 cycles.
//  - Write then read to the same block returns the new data; the write commits before the read is accepted.
//  - Write responses leave resp_rdata unchanged.
//  - Reset mid-operation: FSM returns to IDLE immediately; any uncommitted write is dropped; no resp_ready pulse.
//  - Counter is 8 bits; LATENCY outside 1..255 is a compile-time error (generate-time $error).
// CONFIGURATION
//  BLOCK_MEM_WMASK_EN defined:
//    - req_wmask port exists and is captured on acceptance.
//    - The write commits only bytes whose mask bit is 1; all other bytes keep their old value.
//    - A write with an all-zero mask still completes with a resp_ready pulse and changes nothing.
//  BLOCK_MEM_WMASK_EN undefined:
//    - req_wmask port is absent.
//    - Every write replaces the whole block.
// TESTING
//  1. Preload mem[0]=128'h0..0aabbccdd; read addr 8 -> resp_ready exactly 4 cycles after acceptance;
//     resp_rdata=128'h..aabbccdd; req_ready low for those 4 cycles.
//  2. Write addr 256 (block 16) data 128'h1234... -> pulse after 4 cycles; then read addr 256 -> same data.
//     Also read addr 256+(1<<14) -> same data (alias check).
//  3. req_valid held high continuously, alternating read/write -> acceptances spaced LATENCY+1 cycles apart.
//     One pulse per request; none lost or duplicated.
//  4. Assert rst low 2 cycles after a write to block 5 is accepted -> no pulse; mem[5] unchanged;
//     req_ready=1 while rst is low.
//  5. LATENCY=1 build: read accepted at E0 -> resp_ready in cycle E0+1 with correct data.
//  6. BLOCK_MEM_WMASK_EN, mask=16'h000F, wdata all 0xFF over block of 0x00 -> bytes 0-3 = 0xFF, rest 0x00.
//     Repeat with mask=0 -> block unchanged, pulse still seen.

Source files
------------

// File: rtl/block_mem_backend.sv
// ============================================================================
// Module   : block_mem_backend
// Brief    : Block-granular main memory behind the data cache: serves one
//            refill or writeback at a time after a fixed programmable latency.
//            Optional byte-masked writes when BLOCK_MEM_WMASK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_mem_backend #(
  parameter int BLOCK_BITS  = 128,
  parameter int OFFSET_BITS = 4,
  parameter int DEPTH_LOG2  = 10,
  parameter int LATENCY     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [BLOCK_BITS-1:0]   req_wdata,
`ifdef BLOCK_MEM_WMASK_EN
  input  logic [BLOCK_BITS/8-1:0] req_wmask,
`endif
  output logic                    req_ready,
  output logic                    resp_ready,
  output logic [BLOCK_BITS-1:0]   resp_rdata
);

  localparam int NBYTES = BLOCK_BITS / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int IDX_LO = OFFSET_BITS;
  localparam int IDX_HI = OFFSET_BITS + DEPTH_LOG2 - 1;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_latency_range_err
      $error("block_mem_backend: LATENCY must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [BLOCK_BITS-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]       wmask_q, wmask_d;
  logic [BLOCK_BITS-1:0]   rdata_q, rdata_d;

  logic [BLOCK_BITS-1:0]   mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0]   w_req_idx;
  logic [NBYTES-1:0]       w_req_mask;
  logic                    w_rd_load;
  logic [DEPTH_LOG2-1:0]   w_rd_idx;
  logic [BLOCK_BITS-1:0]   w_commit;
  logic                    unused_addr_bits;

  assign w_req_idx        = req_addr[IDX_HI:IDX_LO];
  assign unused_addr_bits = ^{req_addr[31:IDX_HI+1], req_addr[IDX_LO-1:0]};

`ifdef BLOCK_MEM_WMASK_EN
  assign w_req_mask = req_wmask;
`else
  assign w_req_mask = '1;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_ready = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    w_rd_load = 1'b0;
    w_rd_idx  = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = w_req_idx;
          wdata_d = req_wdata;
          wmask_d = w_req_mask;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            // Single-cycle latency: the response cycle follows acceptance directly.
            state_d   = ST_RESP;
            w_rd_load = !req_write;
            w_rd_idx  = w_req_idx;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 8'd1) begin
          state_d   = ST_RESP;
          cnt_d     = 8'd0;
          w_rd_load = !write_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdata_d = w_rd_load ? mem[w_rd_idx] : rdata_q;
  end

`ifdef BLOCK_MEM_WMASK_EN
  // Unmasked bytes keep the block's current contents.
  always_comb begin
    w_commit = mem[idx_q];
    for (int b = 0; b < NBYTES; b++) begin
      if (wmask_q[b]) begin
        w_commit[b*8 +: 8] = wdata_q[b*8 +: 8];
      end
    end
  end
`else
  logic unused_wmask;
  assign unused_wmask = ^wmask_q;
  assign w_commit     = wdata_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; a reset forces IDLE so a pending write never commits.
  always_ff @(posedge clk) begin
    if (state_q == ST_RESP && write_q) begin
      mem[idx_q] <= w_commit;
    end
  end

endmodule

`default_nettype wire
